morse_seq_ctrl: RTL and testbench

MORSE_SEQ_CTRL -- requirements
Module: morse_seq_ctrl

---
 rtl/morse_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_morse_seq_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/morse_seq_ctrl.sv
// Morse symbol sequencer: snapshots five recorded durations, finds the
// leading run of nonzero fields and its minimum, classifies each counted
// field as dot or dash (dash when >= 2*min), hands the result downstream
// over a valid/ready handshake and then pulses a two-cycle recorder reset.
module morse_seq_ctrl #(
    parameter int unsigned WID = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rec_end,
    input  logic [5*WID-1:0] rec_value,
    output logic             rec_rst,
    output logic [4:0]       sym_bits,
    output logic [2:0]       sym_len,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             busy,
    output logic             err
);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StClass,
        StOut,
        StClr
    } state_e;

    state_e                state_q, state_d;
    logic [4:0][WID-1:0]   buf_q, buf_d;
    logic [2:0]            idx_q, idx_d;
    logic [2:0]            len_q, len_d;
    logic [WID-1:0]        min_q, min_d;
    logic [4:0]            work_q, work_d;
    logic [4:0]            bits_q, bits_d;
    logic [2:0]            slen_q, slen_d;
    logic                  clr_cnt_q, clr_cnt_d;
    logic                  empty_q, empty_d;

    logic [WID-1:0]        field;
    logic                  last_idx;
    logic [WID:0]          field_ext;
    logic [WID:0]          min_x2;

    assign field     = buf_q[idx_q];
    assign last_idx  = (idx_q == 3'd4);
    // One extra bit so 2*min never wraps for large durations.
    assign field_ext = {1'b0, field};
    assign min_x2    = {min_q, 1'b0};

    // Next-state and datapath updates for the scan/classify/handshake sequence.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        len_d     = len_q;
        min_d     = min_q;
        work_d    = work_q;
        bits_d    = bits_q;
        slen_d    = slen_q;
        clr_cnt_d = clr_cnt_q;
        empty_d   = empty_q;

        case (state_q)
            StIdle: begin
                if (rec_end) begin
                    buf_d   = rec_value;
                    idx_d   = 3'd0;
                    len_d   = 3'd0;
                    min_d   = '0;
                    work_d  = '0;
                    state_d = StScan;
                end
            end

            StScan: begin
                // Still counting only while every earlier field was nonzero.
                if ((len_q == idx_q) && (field != '0)) begin
                    len_d = len_q + 3'd1;
                    if ((len_q == 3'd0) || (field < min_q)) begin
                        min_d = field;
                    end
                end
                idx_d = idx_q + 3'd1;
                if (last_idx) begin
                    idx_d     = 3'd0;
                    clr_cnt_d = 1'b0;
                    empty_d   = (len_d == 3'd0);
                    state_d   = (len_d == 3'd0) ? StClr : StClass;
                end
            end

            StClass: begin
                work_d[idx_q] = (idx_q < len_q) && (field_ext >= min_x2);
                idx_d = idx_q + 3'd1;
                if (last_idx) begin
                    idx_d   = 3'd0;
                    bits_d  = work_d;
                    slen_d  = len_q;
                    state_d = StOut;
                end
            end

            StOut: begin
                if (sym_ready) begin
                    clr_cnt_d = 1'b0;
                    empty_d   = 1'b0;
                    state_d   = StClr;
                end
            end

            StClr: begin
                if (!clr_cnt_q) begin
                    clr_cnt_d = 1'b1;
                end else begin
                    clr_cnt_d = 1'b0;
                    empty_d   = 1'b0;
                    state_d   = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            buf_q     <= '0;
            idx_q     <= 3'd0;
            len_q     <= 3'd0;
            min_q     <= '0;
            work_q    <= '0;
            bits_q    <= '0;
            slen_q    <= 3'd0;
            clr_cnt_q <= 1'b0;
            empty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            min_q     <= min_d;
            work_q    <= work_d;
            bits_q    <= bits_d;
            slen_q    <= slen_d;
            clr_cnt_q <= clr_cnt_d;
            empty_q   <= empty_d;
        end
    end

    assign sym_valid = (state_q == StOut);
    assign busy      = (state_q != StIdle);
    assign rec_rst   = (state_q == StClr);
    assign err       = (state_q == StClr) && !clr_cnt_q && empty_q;
    assign sym_bits  = bits_q;
    assign sym_len   = slen_q;

endmodule

// File: tb/tb_morse_seq_ctrl.sv
// Bench for morse_seq_ctrl: directed messages, expected symbol words queued
// on capture and compared when the handshake completes.
module tb_morse_seq_ctrl;

    localparam int unsigned WID = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             rec_end;
    logic [5*WID-1:0] rec_value;
    logic             rec_rst;
    logic [4:0]       sym_bits;
    logic [2:0]       sym_len;
    logic             sym_valid;
    logic             sym_ready;
    logic             busy;
    logic             err;

    int n_total = 0;
    int n_bad   = 0;
    int n_xfer  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    morse_seq_ctrl #(.WID(WID)) dut (
        .clk       (clk),
        .reset     (reset),
        .rec_end   (rec_end),
        .rec_value (rec_value),
        .rec_rst   (rec_rst),
        .sym_bits  (sym_bits),
        .sym_len   (sym_len),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5*WID-1:0] pack5(input logic [WID-1:0] f0, input logic [WID-1:0] f1,
                                               input logic [WID-1:0] f2, input logic [WID-1:0] f3,
                                               input logic [WID-1:0] f4);
        return {f4, f3, f2, f1, f0};
    endfunction

    // Scoreboard side: every completed transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && sym_valid && sym_ready) begin
            n_xfer++;
            check_eq("sb_has_exp", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check_eq("xfer_bits", 64'(sym_bits), 64'(mon_exp[7:3]));
                check_eq("xfer_len", 64'(sym_len), 64'(mon_exp[2:0]));
            end
        end
    end

    // Called at #1 after an edge with the DUT idle; returns the same way.
    task automatic run_msg(input logic [5*WID-1:0] v, input logic [4:0] eb, input logic [2:0] el,
                           input bit empty, input int stall, input bit hold, input bit rdy_early);
        rec_value = v;
        rec_end   = 1'b1;
        if (!empty) exp_q.push_back({eb, el});
        @(posedge clk); #1;
        if (hold) rec_value = pack5(1, 50, 50, 50, 50);
        else rec_end = 1'b0;
        if (rdy_early) sym_ready = 1'b1;
        check_eq("busy_after_cap", 64'(busy), 64'd1);
        if (empty) begin
            repeat (5) @(posedge clk);
            #1;
            check_eq("empty_err", 64'(err), 64'd1);
            check_eq("empty_rst1", 64'(rec_rst), 64'd1);
            check_eq("empty_novalid", 64'(sym_valid), 64'd0);
            @(posedge clk); #1;
            check_eq("empty_err_off", 64'(err), 64'd0);
            check_eq("empty_rst2", 64'(rec_rst), 64'd1);
            @(posedge clk); #1;
            check_eq("empty_rst_off", 64'(rec_rst), 64'd0);
            check_eq("empty_idle", 64'(busy), 64'd0);
        end else begin
            repeat (9) @(posedge clk);
            #1;
            check_eq("valid_early", 64'(sym_valid), 64'd0);
            @(posedge clk); #1;
            check_eq("valid_lat10", 64'(sym_valid), 64'd1);
            check_eq("out_bits", 64'(sym_bits), 64'(eb));
            check_eq("out_len", 64'(sym_len), 64'(el));
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                check_eq("stall_valid", 64'(sym_valid), 64'd1);
                check_eq("stall_bits", 64'(sym_bits), 64'(eb));
                check_eq("stall_len", 64'(sym_len), 64'(el));
            end
            sym_ready = 1'b1;
            @(posedge clk); #1;
            sym_ready = 1'b0;
            check_eq("post_valid", 64'(sym_valid), 64'd0);
            check_eq("clr_rst1", 64'(rec_rst), 64'd1);
            check_eq("clr_noerr", 64'(err), 64'd0);
            @(posedge clk); #1;
            check_eq("clr_rst2", 64'(rec_rst), 64'd1);
            @(posedge clk); #1;
            check_eq("clr_rst_off", 64'(rec_rst), 64'd0);
            check_eq("clr_idle", 64'(busy), 64'd0);
            check_eq("hold_bits", 64'(sym_bits), 64'(eb));
            check_eq("hold_len", 64'(sym_len), 64'(el));
        end
    endtask

    initial begin
        reset     = 1'b1;
        rec_end   = 1'b0;
        sym_ready = 1'b0;
        rec_value = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_valid", 64'(sym_valid), 64'd0);
        check_eq("rst_recrst", 64'(rec_rst), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_bits", 64'(sym_bits), 64'd0);
        check_eq("rst_len", 64'(sym_len), 64'd0);
        reset = 1'b0;

        // Mixed dots/dashes, ready already high during processing.
        run_msg(pack5(10, 30, 10, 0, 0), 5'b00010, 3'd3, 1'b0, 0, 1'b0, 1'b1);
        // Equal fields, downstream stalls for 20 cycles.
        run_msg(pack5(7, 7, 7, 7, 7), 5'b00000, 3'd5, 1'b0, 20, 1'b0, 1'b0);
        // Leading zero -> empty message.
        run_msg(pack5(0, 40, 40, 0, 0), 5'b00000, 3'd0, 1'b1, 0, 1'b0, 1'b0);
        // Extreme durations must not overflow the 2*min compare.
        run_msg(pack5(32'hFFFF_FFFF, 32'h8000_0000, 5, 0, 0), 5'b00011, 3'd3, 1'b0, 0, 1'b0, 1'b0);
        // Single symbol is a dot.
        run_msg(pack5(9, 0, 0, 0, 0), 5'b00000, 3'd1, 1'b0, 0, 1'b0, 1'b0);
        // A zero field ends counting even if later fields are nonzero.
        run_msg(pack5(5, 0, 20, 0, 0), 5'b00000, 3'd1, 1'b0, 2, 1'b0, 1'b0);

        // Abort a message with reset during classification.
        rec_value = pack5(20, 5, 60, 0, 0);
        rec_end   = 1'b1;
        @(posedge clk); #1;
        rec_end = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_eq("abort_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("abort_idle", 64'(busy), 64'd0);
        check_eq("abort_bits", 64'(sym_bits), 64'd0);
        check_eq("abort_len", 64'(sym_len), 64'd0);
        check_eq("abort_recrst", 64'(rec_rst), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check_eq("abort_novalid", 64'(sym_valid), 64'd0);
        run_msg(pack5(3, 9, 0, 0, 0), 5'b00010, 3'd2, 1'b0, 0, 1'b0, 1'b0);

        // rec_end held high across two back-to-back messages.
        run_msg(pack5(6, 2, 0, 0, 0), 5'b00001, 3'd2, 1'b0, 0, 1'b1, 1'b0);
        run_msg(pack5(5, 4, 9, 0, 0), 5'b00100, 3'd3, 1'b0, 0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        check_eq("xfer_count", 64'(n_xfer), 64'd8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
